// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg: shared key levels, default debounce time and a cycle-count helper.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package key_pkg;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    function automatic int unsigned debounce_cycles(
        input int unsigned clk_hz,
        input int unsigned ms
    );
        longint unsigned l_cycles;
        l_cycles = (longint'(clk_hz) * longint'(ms)) / 64'd1000;
        return int'(l_cycles);
    endfunction

endpackage : key_pkg

`default_nettype wire

// File: rtl/key_debounce_chan.sv
// -----------------------------------------------------------------------------
// key_debounce_chan: one key - 2-flop synchroniser, stability counter, strobes.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module key_debounce_chan
    import key_pkg::*;
#(
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_raw,
    output logic o_key_clean,
    output logic o_press,
    output logic o_release
);

    if ((DEBOUNCE_CYCLES < 2) ||
        (longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_WIDTH) - 1))) begin : g_bad_debounce
        $error("key_debounce_chan: DEBOUNCE_CYCLES out of range 2 .. 2**CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_clean;
    logic                 r_press;
    logic                 r_release;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= KEY_RELEASED;
            r_sync2   <= KEY_RELEASED;
            r_cnt     <= '0;
            r_clean   <= KEY_RELEASED;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            // Any cycle that agrees with the clean level discards all accumulated credit
            if (r_sync2 == r_clean) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_clean   <= r_sync2;
                r_cnt     <= '0;
                r_press   <= (r_sync2 == KEY_PRESSED);
                r_release <= (r_sync2 == KEY_RELEASED);
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_key_clean = r_clean;
    assign o_press     = r_press;
    assign o_release   = r_release;

endmodule : key_debounce_chan

`default_nettype wire

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce: NUM_KEYS independent debounce channels for active-low keys.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_clean,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .CNT_WIDTH       (CNT_WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_key_raw   (key_raw[g]),
            .o_key_clean (key_clean[g]),
            .o_press     (press_pulse[g]),
            .o_release   (release_pulse[g])
        );
    end

endmodule : key_debounce

`default_nettype wire

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce: table-driven, scoreboarded bench for key_debounce (D=8).
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_key_debounce;

    localparam int D   = 8;
    localparam int LAT = D + 2;

    typedef struct {
        logic [3:0] raw;
        int         n;
        logic [3:0] clean;
        logic [3:0] press;
        logic [3:0] rel;
    } vec_t;

    typedef struct {
        logic [3:0] clean;
        logic [3:0] press;
        logic [3:0] rel;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] key_clean;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    int   n_checks;
    int   n_errors;
    vec_t vecs[$];
    exp_t sb[$];

    key_debounce #(
        .NUM_KEYS        (4),
        .CNT_WIDTH       (4),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_raw       (key_raw),
        .key_clean     (key_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [3:0] raw, input int n,
                                input logic [3:0] clean, input logic [3:0] press,
                                input logic [3:0] rel);
        vec_t v;
        v.raw = raw; v.n = n; v.clean = clean; v.press = press; v.rel = rel;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Pops the oldest expectation and compares it with what the DUT shows now
    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, " key_clean"}, key_clean, e.clean);
            cmp({tag, " press_pulse"}, press_pulse, e.press);
            cmp({tag, " release_pulse"}, release_pulse, e.rel);
        end
    endtask

    // Called at a falling edge; each cycle of the hold is compared after its rising edge
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        key_raw = v.raw;
        for (int c = 0; c < v.n; c++) begin
            e.clean = v.clean; e.press = v.press; e.rel = v.rel;
            sb.push_back(e);
            @(negedge clk);
            check_sb($sformatf("%s cyc%0d", tag, c));
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("%s vec%0d", tag, i));
        end
        vecs.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, " key_clean"}, key_clean, 4'hF);
        cmp({tag, " press_pulse"}, press_pulse, 4'h0);
        cmp({tag, " release_pulse"}, release_pulse, 4'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b1;
        key_raw  = 4'hF;
        #1 reset_n = 1'b0;
        #1 check_reset_vals("reset_assert");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals($sformatf("in_reset%0d", i));
        end
        reset_n = 1'b1;

        // idle after reset
        add(4'hF, 20, 4'hF, 4'h0, 4'h0);
        // key0 clean press
        add(4'hE, LAT - 1, 4'hF, 4'h0, 4'h0);
        add(4'hE, 1, 4'hE, 4'h1, 4'h0);
        add(4'hE, 5, 4'hE, 4'h0, 4'h0);
        // key1 bounce: low 5, high 1, low 5, high - never accepted
        add(4'hC, 5, 4'hE, 4'h0, 4'h0);
        add(4'hE, 1, 4'hE, 4'h0, 4'h0);
        add(4'hC, 5, 4'hE, 4'h0, 4'h0);
        add(4'hE, 3, 4'hE, 4'h0, 4'h0);
        // key1 stable low
        add(4'hC, LAT - 1, 4'hE, 4'h0, 4'h0);
        add(4'hC, 1, 4'hC, 4'h2, 4'h0);
        add(4'hC, 2, 4'hC, 4'h0, 4'h0);
        // key2 press then clean release
        add(4'h8, LAT - 1, 4'hC, 4'h0, 4'h0);
        add(4'h8, 1, 4'h8, 4'h4, 4'h0);
        add(4'h8, 3, 4'h8, 4'h0, 4'h0);
        add(4'hC, LAT - 1, 4'h8, 4'h0, 4'h0);
        add(4'hC, 1, 4'hC, 4'h0, 4'h4);
        add(4'hC, 3, 4'hC, 4'h0, 4'h0);
        // release remaining keys together
        add(4'hF, LAT - 1, 4'hC, 4'h0, 4'h0);
        add(4'hF, 1, 4'hF, 4'h0, 4'h3);
        add(4'hF, 3, 4'hF, 4'h0, 4'h0);
        // all four keys at once
        add(4'h0, LAT - 1, 4'hF, 4'h0, 4'h0);
        add(4'h0, 1, 4'h0, 4'hF, 4'h0);
        add(4'h0, 3, 4'h0, 4'h0, 4'h0);
        add(4'hF, LAT - 1, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 4'hF, 4'h0, 4'hF);
        add(4'hF, 3, 4'hF, 4'h0, 4'h0);
        run_table("main");

        // Reset mid-count: key0 already clean-pressed, key3 counting
        add(4'hE, LAT - 1, 4'hF, 4'h0, 4'h0);
        add(4'hE, 1, 4'hE, 4'h1, 4'h0);
        add(4'h6, 7, 4'hE, 4'h0, 4'h0);
        run_table("pre_rst");
        #2 reset_n = 1'b0;
        #1 check_reset_vals("midcount_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals($sformatf("midcount_hold%0d", i));
        end
        reset_n = 1'b1;
        add(4'h6, LAT - 1, 4'hF, 4'h0, 4'h0);
        add(4'h6, 1, 4'h6, 4'h9, 4'h0);
        add(4'h6, 5, 4'h6, 4'h0, 4'h0);
        run_table("post_rst");

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_key_debounce

`default_nettype wire
